// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   PS/2 Set-2 keyboard front end. Deserialises raw PS/2 frames, checks
//   parity and stop bit, resolves the E0 (extended) and F0 (break) prefixes
//   and keeps a held/pressed state for a table of up to 16 mapped keys.
//
// Parameters:
//   NUM_KEYS        number of mapped keys (1..16)
//   KEY_CODES       packed NUM_KEYS x 9 bits, entry i = bits [9i+8:9i] = {ext, code}
//   FILTER_CYCLES   identical synchronised samples needed to accept ps2_clk (1..255)
//   TIMEOUT_CYCLES  idle cycles mid-frame before the frame is aborted (>= 16)
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ps2_clk         raw PS/2 clock (asynchronous)
//   ps2_data        raw PS/2 data (asynchronous)
//   key_held        level, bit i = mapped key i down
//   key_press       1-cycle pulse on the rising edge of key_held[i]
//   keycode         last accepted non-prefix scan code
//   keycode_ext     E0 preceded keycode
//   keycode_brk     F0 preceded keycode
//   keycode_valid   1-cycle strobe when the keycode outputs update
//   frame_err       1-cycle strobe on parity, stop-bit or timeout error

// One held/pressed tracker per table entry.
module ps2_key_slot #(
    parameter logic [8:0] CODE = 9'h000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hit,
    input  logic [8:0] code,
    input  logic       brk,
    output logic       held,
    output logic       press
);
    logic match;
    assign match = hit && (code == CODE);

    always_ff @(posedge clk) begin
        if (rst) begin
            held  <= 1'b0;
            press <= 1'b0;
        end else begin
            // Typematic repeats find held already set, so no second pulse.
            press <= match && !brk && !held;
            if (match)
                held <= !brk;
        end
    end
endmodule

module ps2_key_decoder #(
    parameter int                      NUM_KEYS       = 6,
    parameter logic [NUM_KEYS*9-1:0]   KEY_CODES      = {9'h076, 9'h05A, 9'h174, 9'h16B, 9'h172, 9'h175},
    parameter int                      FILTER_CYCLES  = 8,
    parameter int                      TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [7:0]          keycode,
    output logic                keycode_ext,
    output logic                keycode_brk,
    output logic                keycode_valid,
    output logic                frame_err
);
    localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] FILT_MAX = 8'(FILTER_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ---------------- input conditioning ----------------
    logic [1:0] clk_sync, data_sync;
    logic       clk_s, data_s;
    logic       filt;        // filtered ps2_clk
    logic [7:0] filt_cnt;
    logic       fall;        // sample event: filtered clock just fell

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt      <= 1'b1;
            filt_cnt  <= '0;
            fall      <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            fall      <= 1'b0;
            // Count consecutive samples disagreeing with the stable value;
            // any agreeing sample restarts the run.
            if (clk_s == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_MAX) begin
                filt     <= clk_s;
                filt_cnt <= '0;
                fall     <= !clk_s;
            end else begin
                filt_cnt <= filt_cnt + 8'd1;
            end
        end
    end

    // ---------------- frame FSM ----------------
    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       par;
    logic       byte_valid;
    logic       tmo;         // timeout abort, clears prefix flags downstream
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par        <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            tmo        <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            tmo        <= 1'b0;

            case (state)
                IDLE: if (fall && !data_s) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
                DATA: if (fall) begin
                    shift   <= {data_s, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state <= PARITY;
                end
                PARITY: if (fall) begin
                    par   <= data_s;
                    state <= STOP;
                end
                STOP: if (fall) begin
                    if (data_s && (^{shift, par}))
                        byte_valid <= 1'b1;
                    else
                        frame_err  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A sample event always restarts the count, so a stop bit landing
            // on the timeout cycle completes the frame normally.
            if (state == IDLE || fall) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_MAX) begin
                tmo_cnt   <= '0;
                state     <= IDLE;
                frame_err <= 1'b1;
                tmo       <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // ---------------- prefix decoder ----------------
    logic e0, f0;
    logic hit;

    assign hit = byte_valid && (shift != 8'hE0) && (shift != 8'hF0);

    always_ff @(posedge clk) begin
        if (rst) begin
            e0            <= 1'b0;
            f0            <= 1'b0;
            keycode       <= '0;
            keycode_ext   <= 1'b0;
            keycode_brk   <= 1'b0;
            keycode_valid <= 1'b0;
        end else begin
            keycode_valid <= 1'b0;
            if (tmo) begin
                e0 <= 1'b0;
                f0 <= 1'b0;
            end else if (byte_valid) begin
                if (shift == 8'hE0) begin
                    e0 <= 1'b1;
                end else if (shift == 8'hF0) begin
                    f0 <= 1'b1;
                end else begin
                    keycode       <= shift;
                    keycode_ext   <= e0;
                    keycode_brk   <= f0;
                    keycode_valid <= 1'b1;
                    e0            <= 1'b0;
                    f0            <= 1'b0;
                end
            end
        end
    end

    // ---------------- key table ----------------
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        ps2_key_slot #(.CODE(KEY_CODES[9*g +: 9])) u_slot (
            .clk   (clk),
            .rst   (rst),
            .hit   (hit),
            .code  ({e0, shift}),
            .brk   (f0),
            .held  (key_held[g]),
            .press (key_press[g])
        );
    end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 Set-2 keyboard front end: deserialises raw PS/2 frames, checks them, resolves E0 (extended) and F0 (break) prefixes, and keeps a held/pressed state for a configurable table of up to 16 mapped keys. It sits between the board PS/2 pins and the game-control logic. Compared with the previous keyboard block, it adds true press/release tracking, multiple simultaneous keys, extended-code discrimination, parity/framing checking and a stuck-frame timeout.

## Interface
Parameters:
- NUM_KEYS, 6: number of mapped keys, 1..16.
- KEY_CODES, {9'h076,9'h05A,9'h174,9'h16B,9'h172,9'h175}: packed NUM_KEYS×9 bits. Entry i is bits [9i+8:9i], formatted {ext, code}. Default order is index 0 = up, 1 = down, 2 = left, 3 = right, 4 = enter, 5 = esc.
- FILTER_CYCLES, 8: consecutive identical synchronised samples required before ps2_clk is accepted, 1..255.
- TIMEOUT_CYCLES, 100000: idle clk cycles mid-frame before the frame is aborted, ≥ 16.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  reset, synchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- key_held  out  NUM_KEYS  level; bit i = mapped key i currently down.
- key_press  out  NUM_KEYS  1-cycle pulse on the 0→1 transition of key_held[i].
- keycode  out  8  last accepted non-prefix scan code.
- keycode_ext  out  1  E0 prefix preceded keycode.
- keycode_brk  out  1  F0 prefix preceded keycode.
- keycode_valid  out  1  1-cycle strobe; keycode, keycode_ext and keycode_brk update on the same cycle.
- frame_err  out  1  1-cycle strobe on parity error, stop-bit error or timeout.

## Operation
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - The clock filter updates its stable value only after FILTER_CYCLES identical samples.
  - A falling edge of the filtered clock is the sample event F. ps2_data is sampled on F.
- Frame FSM states:
  - IDLE: on F with data = 0 (start bit), go to DATA with bit count 0. On F with data = 1, stay in IDLE and do not flag an error.
  - DATA: on each F, shift the bit in LSB first. After 8 bits, go to PARITY.
  - PARITY: on F, store the bit and go to STOP.
  - STOP: on F, the frame is good if data = 1 and the 9 bits (data + parity) have odd parity. A good frame pulses byte_valid internally; a bad frame pulses frame_err and the byte is discarded. Either way, return to IDLE.
- Timeout:
  - In any state other than IDLE, a counter counts cycles since the last F.
  - When the count reaches TIMEOUT_CYCLES, pulse frame_err, go to IDLE, and clear both prefix flags.
  - The counter resets on every F.
- Prefix decoder, acting on each byte_valid:
  - Byte E0: set e0. No output.
  - Byte F0: set f0. No output.
  - Any other byte: pulse keycode_valid with keycode = byte, keycode_ext = e0, keycode_brk = f0, then clear e0 and f0.
  - For every i where {e0, byte} equals KEY_CODES entry i: key_held[i] is set to !f0.
- key_press[i] = key_held[i] set this cycle while it was clear in the previous cycle.
- Behaviour details:
  - Typematic repeats (repeated make codes) keep key_held high and do not re-pulse key_press.
  - An unmapped code affects only the keycode outputs.
  - A break for a key that is not held causes no change.
  - A frame_err does not alter key_held or the prefix flags, except on timeout (prefix flags cleared as above).
  - Duplicate table entries update every matching bit.
- Reset:
  - All outputs are 0.
  - FSM is in IDLE; counters, prefix flags and the shift register are cleared.
  - The filter stable value is set to 1 and the synchronisers to 1.
  - Reset asserted mid-frame discards the partial frame; no frame_err is generated.

## Timing
- Raw ps2_clk edge to F: 2 (sync) + FILTER_CYCLES cycles.
- Stop-bit F on cycle E:
  - byte_valid and frame_err are registered at E+1.
  - keycode_valid, keycode, keycode_ext, keycode_brk and key_held update at E+2.
  - key_press is high at E+2 for exactly one cycle.
- Strobes are never longer than 1 cycle.
- Bytes arrive at least 11 PS/2 bit times apart, so no back-pressure is needed and none exists.
- Timeout and stop-bit F on the same cycle: F wins, the frame completes normally, and no timeout is raised.

## Test plan
- Send byte 1C with correct odd parity, then F0 1C → keycode_valid twice with keycode = 1C. The first strobe has keycode_brk = 0, the second keycode_brk = 1. key_held stays 0 (unmapped).
- Send E0 75 → key_held = 6'b000001 and key_press[0] pulses for 1 cycle at E+2. Then send 75 without prefix → key_held unchanged, keycode_ext = 0.
- Send E0 75, E0 6B, E0 F0 75 → key_held goes 000001 → 000101 → 000100. key_press fires only for bits 0 and 2, once each.
- Send 5A with the parity bit flipped → frame_err pulses 1 cycle, no keycode_valid, key_held unchanged. Then a frame with stop bit = 0 → frame_err again.
- Send start bit + 4 data bits, then hold ps2_clk high for TIMEOUT_CYCLES → frame_err at the timeout. A following complete 76 frame → key_held[5] = 1.
- Assert rst for 1 cycle during the data bits of an E0 74 sequence with key 0 held → all outputs 0, no frame_err. A subsequent clean E0 74 → key_held = 001000.
